// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path definitions: opcode constants used by the ID-stage
// decoder and the hazard detector, plus the shadow pipeline-stage record.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // Register-address width the shadow record is built for.
  localparam int SHADOW_RD_W = 5;

  // What the hazard detector remembers about an instruction in flight:
  // its destination, whether it writes that destination, and whether it
  // is a load (result only available after MEM).
  typedef struct packed {
    logic [SHADOW_RD_W-1:0] rd;
    logic                   wr;
    logic                   ld;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{rd: '0, wr: 1'b0, ld: 1'b0};

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline stage: a register holding an in-flight instruction
// record. Asynchronous clear on rst_i; bubbleIn loads an empty record
// instead of dIn on the next rising edge.
module hazard_shadow_stage
  import riscv_ctrl_pkg::*;
#(
  parameter type stage_t = shadow_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   bubbleIn,
  input  stage_t dIn,
  output stage_t qOut
);

  // Capture the incoming record, or an empty record when a bubble is inserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qOut <= '0;
    end else if (bubbleIn) begin
      qOut <= '0;
    end else begin
      qOut <= dIn;
    end
  end

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard detector. Tracks its own shadow copies of the EX and MEM
// destination registers and raises a one-cycle bubble request (NoOp_o)
// together with PC / IF-ID hold whenever the ID instruction would read a
// value that is not yet forwardable:
//   - load-use          : load in EX feeding any ID source
//   - branch after ALU  : beq in ID reading an ALU result still in EX
//   - branch after load : beq in ID reading a load result still in MEM
// A lw followed by a dependent beq therefore stalls twice with no FSM.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall / flush
// counters (StallCnt_o, FlushCnt_o) and the CNT_W parameter.
// There is no handshake here: every output is a per-cycle level derived
// combinationally from the ID fields and the registered shadows.
module hazard_detect_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        Op_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic              BranchTaken_i,
  output logic              NoOp_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              Flush_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  StallCnt_o,
  output logic [CNT_W-1:0]  FlushCnt_o
`endif
);

  // The shadow record is sized by the package; the two must agree.
  if (REG_AW != SHADOW_RD_W) begin : gBadWidth
    $error("hazard_detect_unit: REG_AW must equal SHADOW_RD_W");
  end

  logic    idWr;
  logic    idLd;
  logic    idBr;
  logic    idUsesRs1;
  logic    idUsesRs2;
  logic    matchEx;
  logic    matchMem;
  logic    stall;
  shadow_t idRec;
  shadow_t exStage;
  shadow_t memStage;

  // Classify the ID instruction; unknown opcodes touch no registers.
  always_comb begin
    idWr      = 1'b0;
    idLd      = 1'b0;
    idBr      = 1'b0;
    idUsesRs1 = 1'b0;
    idUsesRs2 = 1'b0;
    case (Op_i)
      OP_ITYPE: begin idWr = 1'b1; idUsesRs1 = 1'b1; end
      OP_RTYPE: begin idWr = 1'b1; idUsesRs1 = 1'b1; idUsesRs2 = 1'b1; end
      OP_LW:    begin idWr = 1'b1; idLd = 1'b1; idUsesRs1 = 1'b1; end
      OP_SW:    begin idUsesRs1 = 1'b1; idUsesRs2 = 1'b1; end
      OP_BEQ:   begin idBr = 1'b1; idUsesRs1 = 1'b1; idUsesRs2 = 1'b1; end
      default:  ;
    endcase
  end

  // Does a shadow stage's destination feed one of the ID sources? x0 never does.
  always_comb begin
    matchEx  = (exStage.rd != '0) &&
               ((idUsesRs1 && (exStage.rd == RS1addr_i)) ||
                (idUsesRs2 && (exStage.rd == RS2addr_i)));
    matchMem = (memStage.rd != '0) &&
               ((idUsesRs1 && (memStage.rd == RS1addr_i)) ||
                (idUsesRs2 && (memStage.rd == RS2addr_i)));
  end

  // Stall if any of the three unresolved-dependency cases applies.
  always_comb begin
    stall = (exStage.ld && matchEx) ||
            (idBr && exStage.wr && matchEx) ||
            (idBr && memStage.ld && matchMem);
  end

  // Drive the pipeline controls; reset forces the free-running values and a
  // stall suppresses the branch flush until the branch can actually resolve.
  always_comb begin
    NoOp_o      = 1'b0;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    Flush_o     = 1'b0;
    if (!rst_i) begin
      if (stall) begin
        NoOp_o      = 1'b1;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
      end else begin
        Flush_o = BranchTaken_i & idBr;
      end
    end
  end

  // Record handed to the EX shadow when ID advances.
  always_comb begin
    idRec    = SHADOW_BUBBLE;
    idRec.rd = RDaddr_i;
    idRec.wr = idWr;
    idRec.ld = idLd;
  end

  hazard_shadow_stage #(.stage_t(shadow_t)) uExStage (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubbleIn (stall),
    .dIn      (idRec),
    .qOut     (exStage)
  );

  hazard_shadow_stage #(.stage_t(shadow_t)) uMemStage (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubbleIn (1'b0),
    .dIn      (exStage),
    .qOut     (memStage)
  );

`ifdef HAZARD_PERF_EN
  // Saturating count of stall cycles and issued flushes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      StallCnt_o <= '0;
      FlushCnt_o <= '0;
    end else begin
      if (stall && (StallCnt_o != '1)) begin
        StallCnt_o <= StallCnt_o + 1'b1;
      end
      if (Flush_o && (FlushCnt_o != '1)) begin
        FlushCnt_o <= FlushCnt_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: directed instruction stream with
// hand-computed bubble / flush expectations, queued by the driver and
// checked by an independent monitor on the falling edge.
module tb_hazard_detect_unit;
  import riscv_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] Op_i;
  logic [4:0] RS1addr_i;
  logic [4:0] RS2addr_i;
  logic [4:0] RDaddr_i;
  logic       BranchTaken_i;
  logic       NoOp_o;
  logic       PCWrite_o;
  logic       IFIDWrite_o;
  logic       Flush_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCnt_o;
  logic [31:0] FlushCnt_o;
`endif

  int compared   = 0;
  int mismatched = 0;
  int vecIdx     = 0;

  // expected {noOp, flush} for each cycle driven
  logic [1:0] exp_q[$];

  hazard_detect_unit #(.REG_AW(5)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .Op_i          (Op_i),
    .RS1addr_i     (RS1addr_i),
    .RS2addr_i     (RS2addr_i),
    .RDaddr_i      (RDaddr_i),
    .BranchTaken_i (BranchTaken_i),
    .NoOp_o        (NoOp_o),
    .PCWrite_o     (PCWrite_o),
    .IFIDWrite_o   (IFIDWrite_o),
    .Flush_o       (Flush_o)
`ifdef HAZARD_PERF_EN
    ,
    .StallCnt_o    (StallCnt_o),
    .FlushCnt_o    (FlushCnt_o)
`endif
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #20000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic checkVal(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // driver: present one ID instruction for one cycle and queue its expectation
  task automatic apply(input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic bt, input logic expNoOp,
                       input logic expFlush);
    @(posedge clk_i);
    #1;
    Op_i          = op;
    RS1addr_i     = rs1;
    RS2addr_i     = rs2;
    RDaddr_i      = rd;
    BranchTaken_i = bt;
    exp_q.push_back({expNoOp, expFlush});
  endtask

  // monitor: every falling edge with a pending expectation is one observed output
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkVal($sformatf("vec%0d_noop", vecIdx), int'(NoOp_o), int'(e[1]));
        checkVal($sformatf("vec%0d_pcwrite", vecIdx), int'(PCWrite_o), int'(!e[1]));
        checkVal($sformatf("vec%0d_ifidwrite", vecIdx), int'(IFIDWrite_o), int'(!e[1]));
        checkVal($sformatf("vec%0d_flush", vecIdx), int'(Flush_o), int'(e[0]));
        vecIdx++;
      end
    end
  end

  // stimulus
  initial begin
    rst_i = 1'b1;
    Op_i = '0; RS1addr_i = '0; RS2addr_i = '0; RDaddr_i = '0; BranchTaken_i = 1'b0;
    #3;
    checkVal("rst_noop", int'(NoOp_o), 0);
    checkVal("rst_pcwrite", int'(PCWrite_o), 1);
    checkVal("rst_ifidwrite", int'(IFIDWrite_o), 1);
    checkVal("rst_flush", int'(Flush_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // load-use: lw x5 ; add x6,x5,x7 stalls once
    apply(OP_LW,    5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    apply(OP_RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1, 1'b0);
    apply(OP_RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0);
    // lw x5 ; beq x5,x0 stalls twice
    apply(OP_LW,    5'd2, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    apply(OP_BEQ,   5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    apply(OP_BEQ,   5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    apply(OP_BEQ,   5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    // lw x0 ; add x1,x0,x0 : x0 never hazards
    apply(OP_LW,    5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    apply(OP_RTYPE, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);
    // sw (rd field 5, but not a writer) ; add x7,x5,x5
    apply(OP_SW,    5'd2, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
    apply(OP_RTYPE, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0);
    // addi x3 ; beq x0,x3 taken : stall without flush, then flush
    apply(OP_ITYPE, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0);
    apply(OP_BEQ,   5'd0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
    apply(OP_BEQ,   5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1);
    // 10 independent R-types
    for (int i = 0; i < 10; i++) begin
      apply(OP_RTYPE, 5'd1, 5'd2, 5'(10 + i), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk_i);
`ifdef HAZARD_PERF_EN
    checkVal("stall_cnt", int'(StallCnt_o), 4);
    checkVal("flush_cnt", int'(FlushCnt_o), 1);
`endif

    // asynchronous reset in the middle of a load-use stall
    apply(OP_LW,    5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    apply(OP_RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    checkVal("midrst_noop", int'(NoOp_o), 0);
    checkVal("midrst_pcwrite", int'(PCWrite_o), 1);
    checkVal("midrst_ifidwrite", int'(IFIDWrite_o), 1);
    checkVal("midrst_flush", int'(Flush_o), 0);
`ifdef HAZARD_PERF_EN
    checkVal("midrst_stallcnt", int'(StallCnt_o), 0);
    checkVal("midrst_flushcnt", int'(FlushCnt_o), 0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    // dependent add as first instruction after reset must not stall
    apply(OP_RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0);
    apply(OP_RTYPE, 5'd6, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      @(posedge clk_i);
    end
    @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
